// File: rtl/fp_from_int_arbiter.sv
// -----------------------------------------------------------------------------
// fp_from_int_arbiter
//   Shares one fixed-latency int-to-float conversion unit between NUM_REQ
//   requesters. A round-robin arbiter issues at most one operand per cycle.
//   A tracking shift register runs alongside the conversion unit and carries
//   {valid, requester index, tag}. When a result emerges it is written into
//   that requester's response FIFO. Each requester has a credit count, which
//   is in-flight requests plus FIFO occupancy. A requester is only granted
//   while its credit is below FIFO_DEPTH, so a FIFO write never finds the
//   FIFO full.
//
//   Parameters: NUM_REQ, LATENCY (conversion unit latency), TAG_W, and
//   FIFO_DEPTH. FIFO_DEPTH must be a power of 2 and at least LATENCY+1.
//
// Ports:
//   clk, areset           clock, synchronous active-high reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot)
//   req_data              NUM_REQ x 33-bit signed operands
//   req_tag               NUM_REQ x TAG_W tags
//   conv_a                operand to the conversion unit (0 when no grant)
//   conv_q                conversion result, LATENCY cycles after conv_a
//   resp_valid/resp_ready per-requester response handshake
//   resp_data/resp_tag    per-requester FIFO head (float result and tag)
//   busy                  any request in flight or any FIFO non-empty
// -----------------------------------------------------------------------------
module fp_from_int_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = 7,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*33-1:0]      req_data,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  output logic [32:0]                conv_a,
  input  logic [31:0]                conv_q,
  output logic [NUM_REQ-1:0]         resp_valid,
  input  logic [NUM_REQ-1:0]         resp_ready,
  output logic [NUM_REQ*32-1:0]      resp_data,
  output logic [NUM_REQ*TAG_W-1:0]   resp_tag,
  output logic                       busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant_vec;
  logic               grant_any;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] fifo_wr;
  logic [NUM_REQ-1:0] resp_hs;
  logic [NUM_REQ-1:0] credit_busy;

  logic               trk_vld_q [LATENCY];
  logic [IDX_W-1:0]   trk_idx_q [LATENCY];
  logic [TAG_W-1:0]   trk_tag_q [LATENCY];

  // Round-robin search that starts at rr_q and wraps past NUM_REQ-1.
  // The first eligible index found wins.
  always_comb begin : p_grant
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && eligible[IDX_W'(idx)]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
    if (grant_any) grant_vec[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_any) begin
      rr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign req_ready = grant_vec;
  assign conv_a    = grant_any ? req_data[grant_idx*33 +: 33] : 33'd0;
  assign busy      = !areset && (|credit_busy);

  always_ff @(posedge clk) begin
    if (areset) rr_q <= '0;
    else        rr_q <= rr_d;
  end

  // The tracking pipeline advances every cycle, matching the conversion
  // unit, which never stalls. Only the valids need a reset; index and tag
  // are ignored whenever their stage is not valid.
  always_ff @(posedge clk) begin
    if (areset) begin
      for (int s = 0; s < LATENCY; s++) trk_vld_q[s] <= 1'b0;
    end else begin
      trk_vld_q[0] <= grant_any;
      for (int s = 1; s < LATENCY; s++) trk_vld_q[s] <= trk_vld_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    trk_idx_q[0] <= grant_idx;
    trk_tag_q[0] <= req_tag[grant_idx*TAG_W +: TAG_W];
    for (int s = 1; s < LATENCY; s++) begin
      trk_idx_q[s] <= trk_idx_q[s-1];
      trk_tag_q[s] <= trk_tag_q[s-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [CNT_W-1:0]     credit_q, credit_d;
      logic [PTR_W:0]       wr_ptr_q, rd_ptr_q;
      logic [TAG_W+31:0]    fifo_mem_q [FIFO_DEPTH];
      logic                 fifo_empty, fifo_full;

      assign eligible[gi] = !areset && req_valid[gi] &&
                            (credit_q < CNT_W'(FIFO_DEPTH));
      assign fifo_wr[gi]  = trk_vld_q[LATENCY-1] &&
                            (trk_idx_q[LATENCY-1] == IDX_W'(gi));

      // The extra pointer bit tells a full FIFO from an empty one.
      assign fifo_empty = (wr_ptr_q == rd_ptr_q);
      assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                          (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

      assign resp_valid[gi] = !areset && !fifo_empty;
      assign resp_hs[gi]    = resp_valid[gi] && resp_ready[gi];
      assign {resp_tag[gi*TAG_W +: TAG_W], resp_data[gi*32 +: 32]} =
        fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

      // When a grant and a response handshake happen in the same cycle,
      // they cancel out.
      always_comb begin
        credit_d = credit_q + CNT_W'(grant_vec[gi]) - CNT_W'(resp_hs[gi]);
      end

      assign credit_busy[gi] = (credit_q != '0);

      always_ff @(posedge clk) begin
        if (areset) begin
          credit_q <= '0;
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
        end else begin
          credit_q <= credit_d;
          if (fifo_wr[gi]) wr_ptr_q <= wr_ptr_q + 1'b1;
          if (resp_hs[gi]) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (fifo_wr[gi]) begin
          fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {trk_tag_q[LATENCY-1], conv_q};
        end
      end

      a_no_overflow: assert property (@(posedge clk) disable iff (areset)
        fifo_wr[gi] |-> !fifo_full)
        else $error("response FIFO %0d written while full", gi);
    end
  endgenerate

endmodule

// File: tb/tb_fp_from_int_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_from_int_arbiter
//   Directed bench for fp_from_int_arbiter. It models the shared conversion
//   unit as a LATENCY-deep pipeline around a reference int-to-float function.
//   Background process: each response handshake is checked against the
//   per-requester sequence of operands the bench issued.
// -----------------------------------------------------------------------------
module tb_fp_from_int_arbiter;

  localparam int NR  = 4;
  localparam int LAT = 7;
  localparam int TW  = 4;
  localparam int FD  = 8;

  logic              clk = 1'b0;
  logic              areset;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*33-1:0]  req_data;
  logic [NR*TW-1:0]  req_tag;
  logic [32:0]       conv_a;
  logic [31:0]       conv_q;
  logic [NR-1:0]     resp_valid, resp_ready;
  logic [NR*32-1:0]  resp_data;
  logic [NR*TW-1:0]  resp_tag;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  logic [32:0]   next_op [NR];
  logic [32:0]   exp_seq [NR];
  int            gcount  [NR];
  logic [NR-1:0] last_grant;
  logic          mon_en = 1'b0;
  logic [32:0]   pipe [LAT];

  fp_from_int_arbiter #(.NUM_REQ(NR), .LATENCY(LAT), .TAG_W(TW), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .areset     (areset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_tag    (req_tag),
    .conv_a     (conv_a),
    .conv_q     (conv_q),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference conversion. It is exact up to 24 significant bits and
  // truncates beyond that.
  function automatic logic [31:0] i2f(input logic [32:0] v);
    logic [32:0] mag;
    logic [32:0] norm;
    int msb;
    if (v == 33'd0) return 32'h0;
    mag = v[32] ? (~v + 33'd1) : v;
    msb = 0;
    for (int b = 0; b < 33; b++) if (mag[b]) msb = b;
    if (msb <= 23) norm = mag << (23 - msb);
    else           norm = mag >> (msb - 23);
    return {v[32], 8'(127 + msb), norm[22:0]};
  endfunction

  always @(posedge clk) begin
    pipe[0] <= conv_a;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign conv_q = i2f(pipe[LAT-1]);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Responses for each requester must arrive in issue order.
  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      for (int i = 0; i < NR; i++) begin
        if (resp_valid[i] && resp_ready[i]) begin
          check_eq($sformatf("resp%0d_data", i), 64'(resp_data[i*32 +: 32]), 64'(i2f(exp_seq[i])));
          check_eq($sformatf("resp%0d_tag", i), 64'(resp_tag[i*TW +: TW]), 64'(exp_seq[i][TW-1:0]));
          $display("resp req=%0d data=%h tag=%0d", i, resp_data[i*32 +: 32], resp_tag[i*TW +: TW]);
          exp_seq[i] = exp_seq[i] + 33'd1;
        end
      end
    end
  end

  // One cycle. Each requester presents its next sequence operand, and the
  // grant is sampled after the inputs have settled.
  task automatic cycle_drive(input logic [NR-1:0] v, input logic [NR-1:0] rr_in);
    @(negedge clk);
    req_valid  = v;
    resp_ready = rr_in;
    for (int i = 0; i < NR; i++) begin
      req_data[i*33 +: 33] = next_op[i];
      req_tag[i*TW +: TW]  = next_op[i][TW-1:0];
    end
    #1;
    last_grant = req_ready;
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i]) begin
        next_op[i] = next_op[i] + 33'd1;
        gcount[i]++;
      end
    end
  endtask

  task automatic wait_resp(input int idx, output int lat);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (resp_valid[idx]) lat = k;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && busy; k++) cycle_drive('0, '1);
    check_eq("drain_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int lat;
    int g;
    logic seen;
    areset     = 1'b1;
    req_valid  = '1;
    resp_ready = '0;
    req_data   = '0;
    req_tag    = '0;
    for (int i = 0; i < NR; i++) begin
      next_op[i] = 33'd1;
      exp_seq[i] = 33'd1;
      gcount[i]  = 0;
    end

    // Reset state, with every requester requesting.
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ready", 64'(req_ready), 64'd0);
    check_eq("rst_conv_a", 64'(conv_a), 64'd0);
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);

    // Single request: 3 with tag 5 -> 40400000 after 8 cycles.
    @(negedge clk);
    areset = 1'b0;
    req_valid = 4'b0001;
    req_data[32:0] = 33'h0_0000_0003;
    req_tag[3:0] = 4'd5;
    #1;
    check_eq("single_grant", 64'(req_ready), 64'b0001);
    check_eq("single_conv_a", 64'(conv_a), 64'h3);
    wait_resp(0, lat);
    check_eq("single_latency", 64'(lat), 64'd8);
    check_eq("single_data", 64'(resp_data[31:0]), 64'h40400000);
    check_eq("single_tag", 64'(resp_tag[3:0]), 64'd5);
    @(negedge clk);
    #1;
    check_eq("single_hold", 64'({resp_valid[0], resp_data[31:0]}), 64'h1_40400000);
    @(negedge clk);
    resp_ready = 4'b0001;
    @(negedge clk);
    resp_ready = '0;
    #1;
    check_eq("single_popped", 64'(resp_valid), 64'd0);
    check_eq("single_idle", 64'(busy), 64'd0);
    $display("single: lat=%0d", lat);

    // Negative operand on requester 3: -1 -> BF800000.
    @(negedge clk);
    req_valid = 4'b1000;
    req_data[3*33 +: 33] = 33'h1_FFFF_FFFF;
    req_tag[3*TW +: TW] = 4'd9;
    #1;
    check_eq("neg_grant", 64'(req_ready), 64'b1000);
    wait_resp(3, lat);
    check_eq("neg_latency", 64'(lat), 64'd8);
    check_eq("neg_data", 64'(resp_data[3*32 +: 32]), 64'hBF800000);
    check_eq("neg_tag", 64'(resp_tag[3*TW +: TW]), 64'd9);
    @(negedge clk);
    resp_ready = 4'b1000;
    @(negedge clk);
    resp_ready = '0;
    $display("negative: lat=%0d data=%h", lat, resp_data[3*32 +: 32]);

    // All requesters continuously valid: grants go 0,1,2,3,... with no gaps.
    mon_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cycle_drive(4'b1111, 4'b1111);
      check_eq($sformatf("rr_grant%0d", c), 64'(last_grant), 64'(4'b0001 << (c % 4)));
      $display("rr cycle=%0d grant=%b", c, last_grant);
    end
    drain();
    for (int i = 0; i < NR; i++)
      check_eq($sformatf("rr_resp_cnt%0d", i), 64'(exp_seq[i] - 33'd1), 64'd3);

    // Backpressure: 8 grants to requester 2, then one more per accepted response.
    g = gcount[2];
    for (int c = 0; c < 30; c++) cycle_drive(4'b0100, 4'b1011);
    check_eq("bp_fill_grants", 64'(gcount[2] - g), 64'd8);
    check_eq("bp_blocked", 64'(last_grant), 64'd0);
    cycle_drive(4'b0100, 4'b1111);
    g = gcount[2];
    for (int c = 0; c < 15; c++) cycle_drive(4'b0100, 4'b1011);
    check_eq("bp_one_more", 64'(gcount[2] - g), 64'd1);
    $display("backpressure: extra grants=%0d", gcount[2] - g);
    drain();
    check_eq("bp_all_returned", 64'(exp_seq[2]), 64'(next_op[2]));

    // Requester 1 at full credit: the grant passes to requester 0. Then
    // handshakes and grants in the same cycle leave the credit unchanged.
    g = gcount[1];
    for (int c = 0; c < 20; c++) cycle_drive(4'b0010, 4'b1101);
    check_eq("full_fill_grants", 64'(gcount[1] - g), 64'd8);
    cycle_drive(4'b0011, 4'b1101);
    check_eq("full_pass_grant", 64'(last_grant), 64'b0001);
    g = gcount[1];
    for (int c = 0; c < 12; c++) cycle_drive(4'b0010, 4'b1111);
    check_eq("simul_grants", 64'(gcount[1] - g), 64'd10);
    g = gcount[1];
    for (int c = 0; c < 10; c++) cycle_drive(4'b0010, 4'b1101);
    check_eq("simul_credit_left", 64'(gcount[1] - g), 64'd1);
    $display("simultaneous: residual grants=%0d", gcount[1] - g);
    drain();
    check_eq("simul_all_returned", 64'(exp_seq[1]), 64'(next_op[1]));

    // Reset three cycles after a grant: that result must never appear.
    mon_en = 1'b0;
    cycle_drive(4'b0001, 4'b1111);
    check_eq("rst_mid_grant", 64'(last_grant), 64'b0001);
    cycle_drive('0, 4'b1111);
    cycle_drive('0, 4'b1111);
    @(negedge clk);
    areset = 1'b1;
    req_valid = '1;
    #1;
    check_eq("rst_mid_ready", 64'(req_ready), 64'd0);
    check_eq("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge clk);
    areset = 1'b0;
    req_valid = '0;
    #1;
    check_eq("rst_after_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      cycle_drive('0, '0);
      if (resp_valid != '0) seen = 1'b1;
    end
    check_eq("rst_no_ghost", 64'(seen), 64'd0);
    $display("reset mid-flight: ghost_seen=%0d", seen);

    // Normal operation after reset: 4 -> 40800000.
    next_op[0] = 33'd4;
    cycle_drive(4'b0001, 4'b0000);
    check_eq("post_rst_grant", 64'(last_grant), 64'b0001);
    wait_resp(0, lat);
    check_eq("post_rst_latency", 64'(lat), 64'd8);
    check_eq("post_rst_data", 64'(resp_data[31:0]), 64'h40800000);
    check_eq("post_rst_tag", 64'(resp_tag[3:0]), 64'd4);
    $display("post reset: data=%h", resp_data[31:0]);
    @(negedge clk);
    resp_ready = 4'b0001;
    @(negedge clk);
    resp_ready = '0;
    #1;
    check_eq("final_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
